pc_fetch_unit: RTL

- Instruction-fetch stage of the single-cycle MIPS core: owns the PC, fetches one word per instruction from instruction memory over a req/ack handshake, and holds it for the decode/execute path.
- opcode (instr[31:26]) feeds the main control decoder directly.
- Consumes that decoder's jump/branch outputs plus ALU zero to form the next PC when the instruction retires.

---
 rtl/pc_fetch_unit.sv | 80 ++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS fetch stage owning the PC; fetches over req/ack with a
// sticky timeout fault, holds the instruction until it retires.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        fetch_err
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, retired_q, retired_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        acked, timed_out, retire;
    logic [31:0] br_tgt, next_pc;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_tgt    = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign next_pc   = jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00}
                     : (branch && zero) ? br_tgt : pc_plus4;
    // ack on the last allowed cycle still wins over the timeout
    assign acked     = state_q == S_FETCH && imem_ack;
    assign timed_out = state_q == S_FETCH && !imem_ack && cnt_q == 16'(TIMEOUT - 1);
    assign retire    = state_q == S_EXEC && !stall;

    always_comb begin
        state_d   = acked ? S_EXEC : timed_out ? S_HALT : retire ? S_FETCH : state_q;
        cnt_d     = (state_q == S_FETCH && !acked && !timed_out) ? cnt_q + 16'd1 : 16'd0;
        instr_d   = acked ? imem_rdata : instr_q;
        pc_d      = retire ? next_pc : pc_q;
        retired_d = retire ? retired_q + 32'd1 : retired_q;
        err_d     = err_q | timed_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            cnt_q     <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign imem_req    = state_q == S_FETCH;
    assign instr_valid = state_q == S_EXEC;
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign fetch_err   = err_q;
endmodule
